// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger collision engine: default geometry,
// scan FSM state encoding and the span comparison helper.
package frogger_pkg;

   localparam int DEF_COORD_W     = 6;
   localparam int DEF_CAR_LEN     = 1;
   localparam int DEF_LOG_LEN     = 3;
   localparam int DEF_RIVER_Y_MIN = 1;
   localparam int DEF_RIVER_Y_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCAN_CAR = 2'd1,
      ST_SCAN_LOG = 2'd2,
      ST_REPORT   = 2'd3
   } state_t;

   // True when pos lies within [start - margin, start + len - 1 + margin].
   // Written with additions only, in a width far wider than any coordinate,
   // so neither edge of the playfield can wrap around.
   function automatic logic in_span(input logic [31:0] pos,
                                    input logic [31:0] start,
                                    input logic [31:0] len,
                                    input logic [31:0] margin);
      in_span = ((pos + margin) >= start) && (pos < (start + len + margin));
   endfunction

endpackage

// File: rtl/frogger_span_check.sv
// Combinational row/range comparator. The same instance serves cars (with a
// hit margin) and logs (no margin); the caller muxes the object in.
module frogger_span_check
   import frogger_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W
) (
   input  logic [COORD_W-1:0] frog_x,
   input  logic [COORD_W-1:0] frog_y,
   input  logic [COORD_W-1:0] obj_x,
   input  logic [COORD_W-1:0] obj_y,
   input  logic [31:0]        span_len,
   input  logic [31:0]        span_margin,
   output logic               match
);

   assign match = (frog_y == obj_y) &&
                  in_span(32'(frog_x), 32'(obj_x), span_len, span_margin);

endmodule

// File: rtl/frogger_collision_engine.sv
// Time-multiplexed frog collision engine: snapshots frog/car/log positions on
// a frame tick, scans one object per clock through a shared span comparator
// and reports car-hit / drown flags with a one-cycle valid pulse.
// Optional macro FROGGER_COLL_STATS_EN adds saturating death/drown counters.
module frogger_collision_engine
   import frogger_pkg::*;
#(
   parameter int NUM_CARS     = 5,
   parameter int NUM_LOGS     = 4,
   parameter int COORD_W      = DEF_COORD_W,
   parameter int CAR_LEN      = DEF_CAR_LEN,
   parameter int LOG_LEN      = DEF_LOG_LEN,
   parameter int HIT_MARGIN   = 1,
   parameter int RIVER_Y_MIN  = DEF_RIVER_Y_MIN,
   parameter int RIVER_Y_MAX  = DEF_RIVER_Y_MAX,
   parameter int GRACE_FRAMES = 8
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Frame_Tick,
   input  logic i_Respawn,
   input  logic [COORD_W-1:0] i_Frogger_X,
   input  logic [COORD_W-1:0] i_Frogger_Y,
   input  logic [((NUM_CARS > 0) ? NUM_CARS : 1)*COORD_W-1:0] i_Car_X,
   input  logic [((NUM_CARS > 0) ? NUM_CARS : 1)*COORD_W-1:0] i_Car_Y,
   input  logic [((NUM_LOGS > 0) ? NUM_LOGS : 1)*COORD_W-1:0] i_Log_X,
   input  logic [((NUM_LOGS > 0) ? NUM_LOGS : 1)*COORD_W-1:0] i_Log_Y,
   output logic o_Busy,
   output logic o_Valid,
   output logic o_Collided,
   output logic o_Collided_Log,
   output logic [((NUM_CARS > 1) ? $clog2(NUM_CARS) : 1)-1:0] o_Hit_Idx,
   output logic o_Overrun
`ifdef FROGGER_COLL_STATS_EN
   ,
   output logic [7:0] o_Car_Deaths,
   output logic [7:0] o_Drowns
`endif
);

   localparam int NUM_CARS_A = (NUM_CARS > 0) ? NUM_CARS : 1;
   localparam int NUM_LOGS_A = (NUM_LOGS > 0) ? NUM_LOGS : 1;
   localparam int MAX_OBJ    = (NUM_CARS_A > NUM_LOGS_A) ? NUM_CARS_A : NUM_LOGS_A;
   localparam int CNT_W      = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;
   localparam int HIT_W      = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
   localparam int GRACE_W    = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

   localparam logic [CNT_W-1:0]   LAST_CAR   = CNT_W'(NUM_CARS_A - 1);
   localparam logic [CNT_W-1:0]   LAST_LOG   = CNT_W'(NUM_LOGS_A - 1);
   localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_FRAMES);

   state_t state_r;
   state_t state_nxt_s;
   logic [CNT_W-1:0] idx_r;

   logic [COORD_W-1:0] frog_x_r;
   logic [COORD_W-1:0] frog_y_r;
   logic [NUM_CARS_A*COORD_W-1:0] car_x_r;
   logic [NUM_CARS_A*COORD_W-1:0] car_y_r;
   logic [NUM_LOGS_A*COORD_W-1:0] log_x_r;
   logic [NUM_LOGS_A*COORD_W-1:0] log_y_r;

   logic [COORD_W-1:0] sel_x_s;
   logic [COORD_W-1:0] sel_y_s;
   logic [31:0]        sel_len_s;
   logic [31:0]        sel_margin_s;
   logic               match_s;

   logic             car_hit_acc_r;
   logic             log_sup_acc_r;
   logic [HIT_W-1:0] hit_idx_acc_r;
   logic             car_hit_fin_s;
   logic             log_sup_fin_s;
   logic [HIT_W-1:0] hit_idx_fin_s;

   logic [COORD_W-1:0] frog_y_eff_s;
   logic               drown_s;
   logic               start_s;
   logic               enter_report_s;
   logic               rep_car_s;
   logic               rep_drown_s;

   logic [GRACE_W-1:0] grace_r;
   logic               busy_r;
   logic               valid_r;
   logic               collided_r;
   logic               collided_log_r;
   logic [HIT_W-1:0]   hit_idx_r;
   logic               overrun_r;

   assign start_s        = (state_r == ST_IDLE) && i_Frame_Tick;
   assign enter_report_s = (state_nxt_s == ST_REPORT) && (state_r != ST_REPORT);

   // Scan FSM state register.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Scan FSM next-state: cars, then logs, then a single report cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_Frame_Tick) begin
               if (NUM_CARS > 0)      state_nxt_s = ST_SCAN_CAR;
               else if (NUM_LOGS > 0) state_nxt_s = ST_SCAN_LOG;
               else                   state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCAN_CAR: begin
            if (idx_r == LAST_CAR) begin
               if (NUM_LOGS > 0) state_nxt_s = ST_SCAN_LOG;
               else              state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_SCAN_CAR;
            end
         end
         ST_SCAN_LOG: begin
            if (idx_r == LAST_LOG) state_nxt_s = ST_REPORT;
            else                   state_nxt_s = ST_SCAN_LOG;
         end
         ST_REPORT: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Object index: restarts at 0 on every state change, steps while scanning.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         idx_r <= {CNT_W{1'b0}};
      end else if (state_nxt_s != state_r) begin
         idx_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_SCAN_CAR) || (state_r == ST_SCAN_LOG)) begin
         idx_r <= idx_r + CNT_W'(1);
      end else begin
         idx_r <= {CNT_W{1'b0}};
      end
   end

   // Snapshot of all positions, taken only when a scan starts.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         frog_x_r <= {COORD_W{1'b0}};
         frog_y_r <= {COORD_W{1'b0}};
         car_x_r  <= {(NUM_CARS_A*COORD_W){1'b0}};
         car_y_r  <= {(NUM_CARS_A*COORD_W){1'b0}};
         log_x_r  <= {(NUM_LOGS_A*COORD_W){1'b0}};
         log_y_r  <= {(NUM_LOGS_A*COORD_W){1'b0}};
      end else if (start_s) begin
         frog_x_r <= i_Frogger_X;
         frog_y_r <= i_Frogger_Y;
         car_x_r  <= i_Car_X;
         car_y_r  <= i_Car_Y;
         log_x_r  <= i_Log_X;
         log_y_r  <= i_Log_Y;
      end else begin
         frog_x_r <= frog_x_r;
         frog_y_r <= frog_y_r;
         car_x_r  <= car_x_r;
         car_y_r  <= car_y_r;
         log_x_r  <= log_x_r;
         log_y_r  <= log_y_r;
      end
   end

   // Object mux feeding the shared comparator; car geometry during the car
   // scan, log geometry (no margin) otherwise.
   always_comb begin
      sel_x_s      = {COORD_W{1'b0}};
      sel_y_s      = {COORD_W{1'b0}};
      sel_len_s    = 32'(LOG_LEN);
      sel_margin_s = 32'd0;
      if (state_r == ST_SCAN_CAR) begin
         sel_len_s    = 32'(CAR_LEN);
         sel_margin_s = 32'(HIT_MARGIN);
         for (int k = 0; k < NUM_CARS_A; k++) begin
            sel_x_s = sel_x_s | ((idx_r == CNT_W'(k)) ? car_x_r[k*COORD_W +: COORD_W] : {COORD_W{1'b0}});
            sel_y_s = sel_y_s | ((idx_r == CNT_W'(k)) ? car_y_r[k*COORD_W +: COORD_W] : {COORD_W{1'b0}});
         end
      end else begin
         for (int k = 0; k < NUM_LOGS_A; k++) begin
            sel_x_s = sel_x_s | ((idx_r == CNT_W'(k)) ? log_x_r[k*COORD_W +: COORD_W] : {COORD_W{1'b0}});
            sel_y_s = sel_y_s | ((idx_r == CNT_W'(k)) ? log_y_r[k*COORD_W +: COORD_W] : {COORD_W{1'b0}});
         end
      end
   end

   frogger_span_check #(
      .COORD_W (COORD_W)
   ) u_span_check (
      .frog_x      (frog_x_r),
      .frog_y      (frog_y_r),
      .obj_x       (sel_x_s),
      .obj_y       (sel_y_s),
      .span_len    (sel_len_s),
      .span_margin (sel_margin_s),
      .match       (match_s)
   );

   // Running scan result including the object evaluated this cycle; the first
   // hitting car wins, any supporting log counts.
   always_comb begin
      car_hit_fin_s = car_hit_acc_r;
      hit_idx_fin_s = hit_idx_acc_r;
      log_sup_fin_s = log_sup_acc_r;
      if ((state_r == ST_SCAN_CAR) && match_s && !car_hit_acc_r) begin
         car_hit_fin_s = 1'b1;
         hit_idx_fin_s = HIT_W'(idx_r);
      end else if ((state_r == ST_SCAN_LOG) && match_s) begin
         log_sup_fin_s = 1'b1;
      end else begin
         log_sup_fin_s = log_sup_acc_r;
      end
   end

   // Scan accumulators; held at zero outside an active scan.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         car_hit_acc_r <= 1'b0;
         hit_idx_acc_r <= {HIT_W{1'b0}};
         log_sup_acc_r <= 1'b0;
      end else if ((state_r == ST_IDLE) || (state_r == ST_REPORT)) begin
         car_hit_acc_r <= 1'b0;
         hit_idx_acc_r <= {HIT_W{1'b0}};
         log_sup_acc_r <= 1'b0;
      end else begin
         car_hit_acc_r <= car_hit_fin_s;
         hit_idx_acc_r <= hit_idx_fin_s;
         log_sup_acc_r <= log_sup_fin_s;
      end
   end

   assign frog_y_eff_s = (state_r == ST_IDLE) ? i_Frogger_Y : frog_y_r;
   assign drown_s      = (int'(frog_y_eff_s) >= RIVER_Y_MIN) &&
                         (int'(frog_y_eff_s) <= RIVER_Y_MAX) && !log_sup_fin_s;
   // A respawn on the committing edge, or an active grace count, masks the report.
   assign rep_car_s    = !i_Respawn && (grace_r == {GRACE_W{1'b0}}) && car_hit_fin_s;
   assign rep_drown_s  = !i_Respawn && (grace_r == {GRACE_W{1'b0}}) && drown_s;

   // Registered outputs and grace counter; results commit on entry to REPORT
   // so o_Valid is high during the REPORT cycle.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         busy_r         <= 1'b0;
         valid_r        <= 1'b0;
         overrun_r      <= 1'b0;
         collided_r     <= 1'b0;
         collided_log_r <= 1'b0;
         hit_idx_r      <= {HIT_W{1'b0}};
         grace_r        <= {GRACE_W{1'b0}};
      end else begin
         busy_r    <= (state_nxt_s != ST_IDLE);
         valid_r   <= enter_report_s;
         overrun_r <= i_Frame_Tick && (state_r != ST_IDLE);
         if (enter_report_s) begin
            collided_r     <= rep_car_s;
            collided_log_r <= rep_drown_s;
            if (rep_car_s) hit_idx_r <= hit_idx_fin_s;
            else           hit_idx_r <= hit_idx_r;
            if (i_Respawn)                          grace_r <= GRACE_LOAD;
            else if (grace_r != {GRACE_W{1'b0}})    grace_r <= grace_r - GRACE_W'(1);
            else                                    grace_r <= grace_r;
         end else begin
            collided_r     <= collided_r;
            collided_log_r <= collided_log_r;
            hit_idx_r      <= hit_idx_r;
            if (i_Respawn) grace_r <= GRACE_LOAD;
            else           grace_r <= grace_r;
         end
      end
   end

   assign o_Busy         = busy_r;
   assign o_Valid        = valid_r;
   assign o_Overrun      = overrun_r;
   assign o_Collided     = collided_r;
   assign o_Collided_Log = collided_log_r;
   assign o_Hit_Idx      = hit_idx_r;

`ifdef FROGGER_COLL_STATS_EN
   logic [7:0] car_deaths_r;
   logic [7:0] drowns_r;

   // Saturating counts of reported (post-grace) car deaths and drownings.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         car_deaths_r <= 8'd0;
         drowns_r     <= 8'd0;
      end else begin
         if (enter_report_s && rep_car_s && (car_deaths_r != 8'hFF))
            car_deaths_r <= car_deaths_r + 8'd1;
         else
            car_deaths_r <= car_deaths_r;
         if (enter_report_s && rep_drown_s && (drowns_r != 8'hFF))
            drowns_r <= drowns_r + 8'd1;
         else
            drowns_r <= drowns_r;
      end
   end

   assign o_Car_Deaths = car_deaths_r;
   assign o_Drowns     = drowns_r;
`endif

endmodule

// File: doc/frogger_collision_engine.md
Name: frogger_collision_engine

Overview:
- Parametrised, time-multiplexed collision engine for N cars and M logs.
- On each frame tick it snapshots the frog and object positions, then scans one object per clock.
- It reports a registered car-hit flag, a drown/log flag, a hit index and a result-valid pulse.
- Sits between the object movers and the frog reset/lives logic; replaces the fixed 5-car combinational detector.

Parameters:
- NUM_CARS, 5, number of cars on the car bus.
- NUM_LOGS, 4, number of logs on the log bus.
- COORD_W, 6, width of every X/Y coordinate.
- CAR_LEN, 1, car length in cells (occupies X..X+CAR_LEN-1).
- LOG_LEN, 3, log length in cells.
- HIT_MARGIN, 1, extra cells either side of a car that still count as a hit.
- RIVER_Y_MIN, 1, first river row, inclusive.
- RIVER_Y_MAX, 4, last river row, inclusive.
- GRACE_FRAMES, 8, reports suppressed after a respawn.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Frame_Tick  in  1  one-cycle pulse; starts a scan.
- i_Respawn  in  1  one-cycle pulse; frog respawned, load grace counter.
- i_Frogger_X  in  COORD_W  frog X.
- i_Frogger_Y  in  COORD_W  frog Y.
- i_Car_X  in  NUM_CARS*COORD_W  packed car X; car 0 in the LSBs.
- i_Car_Y  in  NUM_CARS*COORD_W  packed car Y.
- i_Log_X  in  NUM_LOGS*COORD_W  packed log X; log 0 in the LSBs.
- i_Log_Y  in  NUM_LOGS*COORD_W  packed log Y.
- o_Busy  out  1  scan in progress.
- o_Valid  out  1  one-cycle pulse; result registers updated.
- o_Collided  out  1  car hit in the last reported frame.
- o_Collided_Log  out  1  frog in a river row and on no log.
- o_Hit_Idx  out  clog2(max(NUM_CARS,1))  lowest-index car that hit.
- o_Overrun  out  1  one-cycle pulse; tick arrived while busy.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, grace counter 0, snapshot registers 0.
- States and transitions:
  - IDLE: on i_Frame_Tick, snapshot all inputs and go to SCAN_CAR with idx=0.
  - SCAN_CAR: evaluate car[idx], one per clock; after NUM_CARS-1 go to SCAN_LOG with idx=0.
  - SCAN_LOG: evaluate log[idx], one per clock; after NUM_LOGS-1 go to REPORT.
  - REPORT: update the output flags, pulse o_Valid, return to IDLE.
  - Skip SCAN_CAR if NUM_CARS=0; skip SCAN_LOG if NUM_LOGS=0.
- Latency: o_Valid asserts exactly NUM_CARS+NUM_LOGS+1 cycles after the tick cycle. Default: 10.
- o_Busy is high in SCAN_CAR, SCAN_LOG and REPORT.
- Car hit when both hold:
  - Y equal.
  - Frog_X+HIT_MARGIN >= Car_X and Frog_X <= Car_X+CAR_LEN-1+HIT_MARGIN.
  - All sums in COORD_W+2 bits; never subtract, so there is no wrap at X=0 or X=max.
- Exact overlap (Frog_X==Car_X) is a hit.
- Log support: Y equal and Log_X <= Frog_X <= Log_X+LOG_LEN-1, evaluated in COORD_W+1 bits.
- Drown when snapshot Frog_Y is in [RIVER_Y_MIN, RIVER_Y_MAX] and no log supports the frog. Outside the river, drown=0.
- o_Hit_Idx holds the first (lowest) hitting index. It holds its previous value when no car hit.
- Flags and o_Hit_Idx hold until the next REPORT.
- Grace counter:
  - i_Respawn loads GRACE_FRAMES.
  - Each REPORT with counter>0 forces both flags to 0 and decrements the counter.
  - o_Valid still pulses during grace.
- i_Respawn and REPORT in the same cycle: the load wins; the current report is suppressed.
- i_Frame_Tick while busy: ignored, o_Overrun pulses one cycle, the scan is unaffected.
- Tick in the REPORT cycle counts as an overrun.
- Reset asserted mid-scan: immediate return to IDLE and all outputs to 0; no o_Valid.
- Input changes after the snapshot have no effect on the current scan.

Optional Feature:
- Macro: FROGGER_COLL_STATS_EN.
- When defined:
  - Adds outputs o_Car_Deaths and o_Drowns, 8 bits each.
  - Each saturates at 255 and increments on a REPORT whose (post-grace) flag is 1.
  - Both clear on reset.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package frogger_pkg holds:
  - Constants: COORD_W default, RIVER_Y_MIN/MAX, CAR_LEN, LOG_LEN.
  - State encoding: IDLE=0, SCAN_CAR=1, SCAN_LOG=2, REPORT=3.
  - Helper function in_span(pos, start, len, margin).
- One sub-module, frogger_span_check: purely combinational range/row comparator, shared by the car and log paths through a mux on idx.

Test Plan:
- Frog (10,7), car2 at (11,7), others at Y=20; tick → o_Valid 10 cycles later, o_Collided=1, o_Hit_Idx=2, o_Collided_Log=0.
- Frog (0,7), car0 at (0,7), car1 at (63,7) → hit from car0 only, no wrap hit from car1; o_Hit_Idx=0.
- Frog (20,2), log1 at (18,2) → o_Collided_Log=0. Move frog to (21,2) with the log at (18,2) → o_Collided_Log=1.
- Tick, then a second tick 3 cycles later → o_Overrun pulses once; exactly one o_Valid.
- i_Respawn then 9 ticks with the frog overlapping a car → first 8 reports show o_Collided=0, the 9th shows 1.
- Reset pulled low at cycle 4 of a scan → outputs 0, o_Busy=0, no o_Valid; next tick gives a normal 10-cycle result.
